// File: rtl/branch_control_sequencer.sv
// rtl/branch_control_sequencer.sv - fetch/conditional-branch control sequencer for the one-bus datapath
module branch_control_sequencer #(
    parameter logic [4:0] BR_OPCODE = 5'b11010
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    input  logic [31:0] bus,
    output logic        pc_out,
    output logic        mar_in,
    output logic        inc_pc,
    output logic        mdr_read,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        ir_in,
    output logic        gra,
    output logic        r_out,
    output logic        con_in,
    output logic        y_in,
    output logic        c_out,
    output logic        alu_add,
    output logic        zlo_in,
    output logic        zlo_out,
    output logic        pc_in,
    output logic        con,
    output logic        halted
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    state_t state;
    state_t state_next;
    logic   cond_val;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        unique case (ir[20:19])
            2'b00:   cond_val = (bus == 32'd0);
            2'b01:   cond_val = (bus != 32'd0);
            2'b10:   cond_val = ~bus[31] && (bus != 32'd0);
            default: cond_val = bus[31];
        endcase
    end

    // CON is only written on the edge leaving T3 and otherwise holds across instructions
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            con <= 1'b0;
        end else if (state == S_T3) begin
            con <= cond_val;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = run ? S_T0 : S_IDLE;
            S_T0:    state_next = S_T1;
            S_T1:    state_next = mem_ready ? S_T2 : S_T1;
            // IR is loaded on this same edge, so the opcode is taken from the bus
            S_T2:    state_next = (bus[31:27] == BR_OPCODE) ? S_T3 : S_HALT;
            S_T3:    state_next = S_T4;
            S_T4:    state_next = S_T5;
            S_T5:    state_next = S_T6;
            S_T6:    state_next = run ? S_T0 : S_IDLE;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pc_out   = 1'b0;
        mar_in   = 1'b0;
        inc_pc   = 1'b0;
        mdr_read = 1'b0;
        mdr_in   = 1'b0;
        mdr_out  = 1'b0;
        ir_in    = 1'b0;
        gra      = 1'b0;
        r_out    = 1'b0;
        con_in   = 1'b0;
        y_in     = 1'b0;
        c_out    = 1'b0;
        alu_add  = 1'b0;
        zlo_in   = 1'b0;
        zlo_out  = 1'b0;
        pc_in    = 1'b0;
        halted   = 1'b0;
        case (state)
            S_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
            end
            S_T1: begin
                mdr_read = 1'b1;
                mdr_in   = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                gra    = 1'b1;
                r_out  = 1'b1;
                con_in = 1'b1;
            end
            S_T4: begin
                pc_out = 1'b1;
                y_in   = 1'b1;
            end
            S_T5: begin
                c_out   = 1'b1;
                alu_add = 1'b1;
                zlo_in  = 1'b1;
            end
            S_T6: begin
                zlo_out = 1'b1;
                pc_in   = con;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_branch_control_sequencer.sv
// tb/tb_branch_control_sequencer.sv - directed scoreboard bench for branch_control_sequencer
module tb_branch_control_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        run;
    logic        mem_ready;
    logic [31:0] ir;
    logic [31:0] bus;
    logic pc_out, mar_in, inc_pc, mdr_read, mdr_in, mdr_out, ir_in, gra, r_out, con_in;
    logic y_in, c_out, alu_add, zlo_in, zlo_out, pc_in, con, halted;

    branch_control_sequencer dut (
        .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .ir(ir), .bus(bus),
        .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .mdr_read(mdr_read),
        .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .gra(gra), .r_out(r_out),
        .con_in(con_in), .y_in(y_in), .c_out(c_out), .alu_add(alu_add), .zlo_in(zlo_in),
        .zlo_out(zlo_out), .pc_in(pc_in), .con(con), .halted(halted)
    );

    always #5 clk = ~clk;

    // {pc_out,mar_in,inc_pc,mdr_read,mdr_in,mdr_out,ir_in,gra,r_out,con_in,
    //  y_in,c_out,alu_add,zlo_in,zlo_out,pc_in,con,halted}
    localparam logic [17:0] E_IDLE = 18'h00000;
    localparam logic [17:0] E_T0   = 18'h38000;
    localparam logic [17:0] E_T1   = 18'h06000;
    localparam logic [17:0] E_T2   = 18'h01800;
    localparam logic [17:0] E_T3   = 18'h00700;
    localparam logic [17:0] E_T4   = 18'h20080;
    localparam logic [17:0] E_T5   = 18'h00070;
    localparam logic [17:0] E_T6   = 18'h00008;
    localparam logic [17:0] E_PCIN = 18'h00004;
    localparam logic [17:0] E_CON  = 18'h00002;
    localparam logic [17:0] E_HALT = 18'h00001;

    logic [17:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          start_cyc;
    logic        model_con = 1'b0;

    function automatic logic [17:0] observed();
        return {pc_out, mar_in, inc_pc, mdr_read, mdr_in, mdr_out, ir_in, gra, r_out, con_in,
                y_in, c_out, alu_add, zlo_in, zlo_out, pc_in, con, halted};
    endfunction

    function automatic logic [17:0] with_con(input logic [17:0] e);
        return model_con ? (e | E_CON) : e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic expect_out(input logic [17:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        logic [17:0] e;
        logic [17:0] o;
        e = exp_q.pop_front();
        o = observed();
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // Called one time unit after the edge that entered T0; leaves the FSM entering T3 (or HALT)
    task automatic fetch(input logic [31:0] word, input int waits, input string tag);
        start_cyc = cyc;
        expect_out(with_con(E_T0)); check_out({tag, "_t0"});
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < waits; i++) begin
            expect_out(with_con(E_T1)); check_out({tag, "_t1_wait"});
            tick();
        end
        mem_ready = 1'b1;
        expect_out(with_con(E_T1)); check_out({tag, "_t1"});
        tick();
        ir  = 32'h0;
        bus = word;
        expect_out(with_con(E_T2)); check_out({tag, "_t2"});
        tick();
    endtask

    task automatic exec(input logic [31:0] word, input logic [31:0] ra, input logic exp_con,
                        input logic run_next, input int waits, input string tag);
        ir  = word;
        bus = ra;
        expect_out(with_con(E_T3)); check_out({tag, "_t3"});
        tick();
        model_con = exp_con;
        bus = 32'hFFFF_FFFF;
        expect_out(with_con(E_T4)); check_out({tag, "_t4"});
        tick();
        expect_out(with_con(E_T5)); check_out({tag, "_t5"});
        tick();
        expect_out(with_con(exp_con ? (E_T6 | E_PCIN) : E_T6)); check_out({tag, "_t6"});
        run = run_next;
        tick();
        check_int({tag, "_cycles"}, cyc - start_cyc, 7 + waits);
    endtask

    initial begin
        clr = 1'b1; run = 1'b1; mem_ready = 1'b1; ir = 32'h0; bus = 32'h0;
        tick(); tick();
        expect_out(E_IDLE); check_out("reset_idle_run_ignored");
        clr = 1'b0;
        tick();

        fetch(32'hD01001FF, 0, "pos_taken");
        exec(32'hD01001FF, 32'h00000022, 1'b1, 1'b1, 0, "pos_taken");

        fetch(32'hD00001FF, 0, "zero_not_taken");
        exec(32'hD00001FF, 32'h00000012, 1'b0, 1'b1, 0, "zero_not_taken");

        fetch(32'hD01801FF, 0, "neg_boundary");
        exec(32'hD01801FF, 32'h80000000, 1'b1, 1'b1, 0, "neg_boundary");

        fetch(32'hD01001FF, 0, "pos_zero");
        exec(32'hD01001FF, 32'h00000000, 1'b0, 1'b0, 0, "pos_zero");
        expect_out(with_con(E_IDLE)); check_out("idle_after_run_low");
        tick();
        expect_out(with_con(E_IDLE)); check_out("idle_hold");
        run = 1'b1;
        tick();

        fetch(32'hD00801FF, 3, "mem_wait");
        exec(32'hD00801FF, 32'h00000005, 1'b1, 1'b1, 3, "mem_wait");

        fetch(32'hD00001FF, 0, "zero_taken");
        exec(32'hD00001FF, 32'h00000000, 1'b1, 1'b1, 0, "zero_taken");

        fetch(32'hD01801FF, 0, "reset_mid");
        ir = 32'hD01801FF; bus = 32'h7FFFFFFF;
        expect_out(with_con(E_T3)); check_out("reset_mid_t3");
        tick();
        model_con = 1'b0;
        expect_out(E_T4); check_out("reset_mid_t4");
        clr = 1'b1;
        #1;
        model_con = 1'b0;
        expect_out(E_IDLE); check_out("reset_async_immediate");
        tick();
        expect_out(E_IDLE); check_out("reset_held");
        clr = 1'b0;
        tick();

        fetch(32'hC00001FF, 0, "illegal");
        for (int i = 0; i < 4; i++) begin
            expect_out(E_HALT); check_out("halt_hold");
            tick();
        end
        check_int("halt_latency", cyc - start_cyc, 7);
        clr = 1'b1;
        #1;
        expect_out(E_IDLE); check_out("halt_cleared");
        clr = 1'b0; run = 1'b0;
        tick();
        expect_out(E_IDLE); check_out("idle_after_clear");

        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
